// File: rtl/mips_pkg.sv
// Shared MIPS types and constants, plus the flop macro used for state registers.
// The flop macro expects the enclosing module to have clk and an active-low async rst.
`ifndef MIPS_FF
`define MIPS_FF(q, d, rv) always_ff @(posedge clk or negedge rst) if (!rst) q <= (rv); else q <= (d);
`endif

package mips_pkg;

    localparam int DATA_32_W = 32;
    localparam int LSU_LANES = DATA_32_W / 8;

    typedef enum logic [1:0] {
        BYTE = 2'b00,
        HALF = 2'b01,
        WORD = 2'b10
    } lsu_size_e;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        RD   = 2'b01,
        WR   = 2'b10,
        RESP = 2'b11
    } lsu_state_e;

    // Encoding 2'b11 has no defined size, so it is treated as misaligned.
    function automatic logic lsu_misaligned(input logic [1:0] size, input logic [1:0] lane);
        case (size)
            BYTE:    return 1'b0;
            HALF:    return lane[0];
            WORD:    return |lane;
            default: return 1'b1;
        endcase
    endfunction

endpackage

// File: rtl/mips_lsu_align.sv
// Lane steering for the LSU: extracts and extends load data, and merges
// sub-word store data into a word read back from memory.
module lsu_align
    import mips_pkg::*;
#(
    parameter int DATA_W = 32
) (
    input  logic [1:0]        size,
    input  logic [1:0]        lane,
    input  logic              is_signed,
    input  logic [DATA_W-1:0] word,
    input  logic [DATA_W-1:0] sdata,
    output logic [DATA_W-1:0] load_val,
    output logic [DATA_W-1:0] store_word
);

    logic [LSU_LANES-1:0] be;
    logic [DATA_W-1:0]    repl;
    logic [7:0]           byte_v;
    logic [15:0]          half_v;

    assign byte_v = word[{lane, 3'b000} +: 8];
    assign half_v = word[{lane[1], 4'b0000} +: 16];

    always_comb begin
        be       = '0;
        repl     = sdata;
        load_val = word;
        case (size)
            BYTE: begin
                be[lane] = 1'b1;
                repl     = {4{sdata[7:0]}};
                load_val = {{(DATA_W-8){is_signed & byte_v[7]}}, byte_v};
            end
            HALF: begin
                be[{lane[1], 1'b0}] = 1'b1;
                be[{lane[1], 1'b1}] = 1'b1;
                repl     = {2{sdata[15:0]}};
                load_val = {{(DATA_W-16){is_signed & half_v[15]}}, half_v};
            end
            WORD: be = '1;
            default: be = '0;
        endcase
    end

    // Replicated store data lets each enabled lane take its bytes from the same position.
    always_comb begin
        store_word = word;
        for (int i = 0; i < LSU_LANES; i++)
            store_word[i*8 +: 8] = be[i] ? repl[i*8 +: 8] : word[i*8 +: 8];
    end

endmodule

// File: rtl/mips_lsu.sv
// Load/store unit driving a word-only data memory; sub-word stores go
// through a read-modify-write, errors complete without touching memory.
module mips_lsu
    import mips_pkg::*;
#(
    parameter int DATA_W    = 32,
    parameter int ADDR_W    = 32,
    parameter int MEM_DEPTH = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [1:0]        req_size,
    input  logic              req_signed,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              resp_valid,
    output logic [DATA_W-1:0] resp_rdata,
    output logic              resp_err,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_write,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata
);

    localparam logic [ADDR_W-1:0] ADDR_LIMIT = ADDR_W'(MEM_DEPTH * 4);

    lsu_state_e        state, state_d;
    logic              we_q, signed_q, err_q;
    logic [1:0]        size_q;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] wdata_q, word_buf;
    logic [DATA_W-1:0] load_val, store_word;
    logic              accept, req_err, mem_phase;

    assign req_ready = (state == IDLE);
    assign accept    = req_valid & req_ready;
    assign req_err   = lsu_misaligned(req_size, req_addr[1:0]) || (req_addr >= ADDR_LIMIT);

    always_comb begin
        state_d = state;
        case (state)
            IDLE: if (accept) begin
                if (req_err)             state_d = RESP;
                else if (!req_we)        state_d = RD;
                else if (req_size == WORD) state_d = WR;
                else                     state_d = RD;
            end
            RD:      state_d = we_q ? WR : RESP;
            WR:      state_d = RESP;
            default: state_d = IDLE;
        endcase
    end

    `MIPS_FF(state, state_d, IDLE)

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            we_q     <= 1'b0;
            signed_q <= 1'b0;
            err_q    <= 1'b0;
            size_q   <= '0;
            addr_q   <= '0;
            wdata_q  <= '0;
            word_buf <= '0;
        end else begin
            if (accept) begin
                we_q     <= req_we;
                signed_q <= req_signed;
                err_q    <= req_err;
                size_q   <= req_size;
                addr_q   <= req_addr;
                wdata_q  <= req_wdata;
            end
            if (state == RD)
                word_buf <= mem_rdata;
        end
    end

    lsu_align #(.DATA_W(DATA_W)) u_align (
        .size       (size_q),
        .lane       (addr_q[1:0]),
        .is_signed  (signed_q),
        .word       (word_buf),
        .sdata      (wdata_q),
        .load_val   (load_val),
        .store_word (store_word)
    );

    // Memory outputs are held at zero outside the access states so reset and idle look identical.
    assign mem_phase  = (state == RD) || (state == WR);
    assign mem_addr   = mem_phase ? {addr_q[ADDR_W-1:2], 2'b00} : '0;
    assign mem_write  = (state == WR);
    assign mem_wdata  = (state == WR) ? ((size_q == WORD) ? wdata_q : store_word) : '0;

    assign resp_valid = (state == RESP);
    assign resp_err   = (state == RESP) & err_q;
    assign resp_rdata = ((state == RESP) && !we_q && !err_q) ? load_val : '0;

endmodule
